// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time tester: game state codes,
// the untracked-result marker and the wait-delay helper.
package reaction;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_WAIT  = 3'b001,
        ST_GREEN = 3'b010,
        ST_LATE  = 3'b011,
        ST_EARLY = 3'b110,
        ST_DONE  = 3'b100
    } reaction_state_e;

    localparam int unsigned RESULT_W         = 28;
    localparam logic [27:0] RESULT_UNTRACKED = 28'hFFFFFFF;

    // Wait delay = fixed part plus the shifted PRNG word, formed 32 bits wide.
    function automatic logic [31:0] delay_load(input logic [31:0] base,
                                               input logic [15:0] rnd,
                                               input int unsigned shift);
        return base + ({16'h0000, rnd} << shift);
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Push-button conditioning: 2-FF synchronizer, stability counter that accepts
// a new level after DEBOUNCE_CYCLES stable cycles, and registered rising-edge pulse.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic [CNT_W-1:0] cnt_r;
    logic             level_r;
    logic             level_d_r;
    logic             rise_r;

    // Synchronizer, stability counter, debounced level and edge pulse.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync1_r   <= 1'b0;
            sync2_r   <= 1'b0;
            cnt_r     <= '0;
            level_r   <= 1'b0;
            level_d_r <= 1'b0;
            rise_r    <= 1'b0;
        end else begin
            sync1_r   <= i_raw;
            sync2_r   <= sync1_r;
            level_d_r <= level_r;
            rise_r    <= level_r & ~level_d_r;
            if (sync2_r != level_r) begin
                if (cnt_r == CNT_LAST) begin
                    level_r <= sync2_r;
                    cnt_r   <= '0;
                end else begin
                    cnt_r   <= cnt_r + CNT_W'(1);
                end
            end else begin
                cnt_r <= '0;
            end
        end
    end

    assign o_level = level_r;
    assign o_rise  = rise_r;

endmodule

// File: rtl/reaction_timer.sv
// Reaction-time game controller: wait -> green -> hit/early/late sequence,
// reaction measurement in clock cycles, last and best result registers.
module reaction_timer
    import reaction::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000,
    parameter int unsigned DELAY_MIN       = 50_000_000,
    parameter int unsigned DELAY_SHIFT     = 10,
    parameter int unsigned TIMEOUT         = 100_000_000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_button,
    input  logic [15:0] i_rnd,
    output logic [2:0]  o_reaction_state,
    output logic [27:0] o_last_result,
    output logic [27:0] o_best_result,
    output logic        o_green
);

    localparam logic [27:0] TIMEOUT_LAST = 28'(TIMEOUT - 1);

    reaction_state_e state_r;
    reaction_state_e state_nxt_s;
    logic [31:0]     delay_cnt_r;
    logic [27:0]     react_cnt_r;
    logic [27:0]     last_r;
    logic [27:0]     best_r;
    logic            green_r;

    logic level_s;
    logic rise_s;
    logic press_s;
    logic load_delay_s;
    logic enter_green_s;
    logic hit_s;
    logic untracked_s;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_raw   (i_button),
        .o_level (level_s),
        .o_rise  (rise_s)
    );

    // A rise is only taken while the debounced level is still high.
    assign press_s = rise_s & level_s;

    // Next-state decode and the one-cycle strobes that update counters and results.
    always_comb begin
        state_nxt_s   = state_r;
        load_delay_s  = 1'b0;
        enter_green_s = 1'b0;
        hit_s         = 1'b0;
        untracked_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (press_s) begin
                    state_nxt_s  = ST_WAIT;
                    load_delay_s = 1'b1;
                end else begin
                    state_nxt_s  = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (press_s) begin
                    state_nxt_s   = ST_EARLY;
                    untracked_s   = 1'b1;
                end else if (delay_cnt_r <= 32'd1) begin
                    state_nxt_s   = ST_GREEN;
                    enter_green_s = 1'b1;
                end else begin
                    state_nxt_s   = ST_WAIT;
                end
            end
            ST_GREEN: begin
                if (press_s) begin
                    state_nxt_s = ST_DONE;
                    hit_s       = 1'b1;
                end else if (react_cnt_r == TIMEOUT_LAST) begin
                    state_nxt_s = ST_LATE;
                    untracked_s = 1'b1;
                end else begin
                    state_nxt_s = ST_GREEN;
                end
            end
            ST_LATE, ST_EARLY, ST_DONE: begin
                if (press_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register and the green LED decode of the next registered state.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
            green_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            green_r <= (state_nxt_s == ST_GREEN);
        end
    end

    // Wait-phase delay counter, loaded on arming and run down while waiting.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            delay_cnt_r <= 32'd0;
        end else if (load_delay_s) begin
            delay_cnt_r <= delay_load(32'(DELAY_MIN), i_rnd, DELAY_SHIFT);
        end else if ((state_r == ST_WAIT) && (delay_cnt_r != 32'd0)) begin
            delay_cnt_r <= delay_cnt_r - 32'd1;
        end else begin
            delay_cnt_r <= delay_cnt_r;
        end
    end

    // Reaction counter: zero on the first green cycle, counting up while green.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            react_cnt_r <= 28'd0;
        end else if (enter_green_s) begin
            react_cnt_r <= 28'd0;
        end else if (state_r == ST_GREEN) begin
            react_cnt_r <= react_cnt_r + 28'd1;
        end else begin
            react_cnt_r <= react_cnt_r;
        end
    end

    // Last/best results change only on entry to DONE, LATE or EARLY.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            last_r <= RESULT_UNTRACKED;
            best_r <= RESULT_UNTRACKED;
        end else if (hit_s) begin
            last_r <= react_cnt_r;
            if (react_cnt_r < best_r) begin
                best_r <= react_cnt_r;
            end else begin
                best_r <= best_r;
            end
        end else if (untracked_s) begin
            last_r <= RESULT_UNTRACKED;
            best_r <= best_r;
        end else begin
            last_r <= last_r;
            best_r <= best_r;
        end
    end

    assign o_reaction_state = state_r;
    assign o_last_result    = last_r;
    assign o_best_result    = best_r;
    assign o_green          = green_r;

endmodule

// File: tb/tb_reaction_timer.sv
// Scoreboard bench for reaction_timer: expected state/results are queued when a
// press or phase is launched and compared when the DUT's state changes.
module tb_reaction_timer;
    import reaction::*;

    localparam int unsigned DEB  = 4;
    localparam int unsigned DMIN = 20;
    localparam int unsigned DSH  = 0;
    localparam int unsigned TMO  = 50;
    localparam int unsigned LAT  = 7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        button;
    logic [15:0] rnd;
    logic [2:0]  state;
    logic [27:0] last_res;
    logic [27:0] best_res;
    logic        green;

    always #5 clk = ~clk;

    reaction_timer #(
        .DEBOUNCE_CYCLES(DEB),
        .DELAY_MIN      (DMIN),
        .DELAY_SHIFT    (DSH),
        .TIMEOUT        (TMO)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_button        (button),
        .i_rnd           (rnd),
        .o_reaction_state(state),
        .o_last_result   (last_res),
        .o_best_result   (best_res),
        .o_green         (green)
    );

    typedef struct {
        string       tag;
        logic [2:0]  st;
        logic [27:0] last;
        logic [27:0] best;
        logic        grn;
    } exp_t;

    exp_t        exp_q[$];
    int          checks_cnt = 0;
    int          errors_cnt = 0;
    logic [27:0] last_m = 28'hFFFFFFF;
    logic [27:0] best_m = 28'hFFFFFFF;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks_cnt++;
        if (act !== exp) begin
            errors_cnt++;
            $display("FAIL %s: actual %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string tag, input logic [2:0] st);
        exp_t e;
        e.tag  = tag;
        e.st   = st;
        e.last = last_m;
        e.best = best_m;
        e.grn  = (st == 3'b010);
        exp_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        chk("sb_depth", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({e.tag, ".state"}, 32'(state), 32'(e.st));
            chk({e.tag, ".last"}, 32'(last_res), 32'(e.last));
            chk({e.tag, ".best"}, 32'(best_res), 32'(e.best));
            chk({e.tag, ".green"}, 32'(green), 32'(e.grn));
        end
    endtask

    task automatic wait_change(input int budget, output int n);
        logic [2:0] prev;
        prev = state;
        n = 0;
        while ((state === prev) && (n < budget)) begin
            tick();
            n++;
        end
    endtask

    // Clean press: released once the debouncer has accepted it, then wait for the state move.
    task automatic press_check(input string tag, input int settle);
        logic [2:0] prev;
        int n;
        prev = state;
        n = 0;
        button = 1'b1;
        while ((state === prev) && (n < 40)) begin
            tick();
            n++;
            if (n == 7) button = 1'b0;
        end
        button = 1'b0;
        chk({tag, ".latency"}, 32'(n), 32'(LAT + 1));
        pop_check();
        repeat (settle) tick();
    endtask

    task automatic arm(input string tag, input logic [15:0] r);
        int n;
        rnd = r;
        push_exp({tag, ".arm"}, ST_WAIT);
        press_check({tag, ".arm"}, 0);
        rnd = ~r;
        push_exp({tag, ".green"}, ST_GREEN);
        wait_change(400, n);
        chk({tag, ".wait_len"}, 32'(n), DMIN + ({16'h0000, r} << DSH));
        pop_check();
    endtask

    task automatic attempt(input string tag, input logic [15:0] r, input int rt_delay);
        arm(tag, r);
        repeat (rt_delay) tick();
        last_m = 28'(rt_delay + LAT);
        if (last_m < best_m) best_m = last_m;
        push_exp({tag, ".hit"}, ST_DONE);
        press_check({tag, ".hit"}, 10);
        push_exp({tag, ".rearm"}, ST_IDLE);
        press_check({tag, ".rearm"}, 10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n  = 1'b0;
        button = 1'b0;
        rnd    = 16'h0000;
        repeat (3) tick();
        rst_n = 1'b1;
        push_exp("reset", ST_IDLE);
        repeat (100) tick();
        pop_check();

        attempt("a1", 16'd5, 10);
        attempt("a2", 16'd9, 23);
        attempt("a3", 16'd2, 5);

        // Press five cycles into the wait phase.
        rnd = 16'd5;
        push_exp("e.arm", ST_WAIT);
        press_check("e.arm", 0);
        repeat (5) tick();
        last_m = RESULT_UNTRACKED;
        push_exp("e.early", ST_EARLY);
        press_check("e.early", 10);
        push_exp("e.back", ST_IDLE);
        press_check("e.back", 10);

        // No press while green.
        arm("l", 16'd0);
        last_m = RESULT_UNTRACKED;
        push_exp("l.late", ST_LATE);
        wait_change(200, n);
        chk("l.late_len", 32'(n), TMO);
        pop_check();
        push_exp("l.back", ST_IDLE);
        press_check("l.back", 10);

        // Glitches and short pulses must not count as presses.
        push_exp("bounce", ST_IDLE);
        for (int k = 0; k < 4; k++) begin
            button = 1'b1;
            tick();
            button = 1'b0;
            repeat (3) tick();
            button = 1'b1;
            repeat (3) tick();
            button = 1'b0;
            repeat (3) tick();
        end
        repeat (10) tick();
        pop_check();

        // Reset mid-green clears everything, including best.
        arm("r", 16'd1);
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        last_m = RESULT_UNTRACKED;
        best_m = RESULT_UNTRACKED;
        push_exp("r.reset", ST_IDLE);
        pop_check();
        rst_n = 1'b1;
        repeat (10) tick();

        attempt("p", 16'd3, 8);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/reaction_timer.md
# reaction_timer

Game controller for the reaction-time tester: debounces the G16 push-button, runs the wait → green → hit/early/late sequence, measures reaction time in clock cycles and keeps the last and best results. Its outputs (state code, last result, best result) feed `state_transfer`, which samples them once per offscreen interval and renders them. The random wait delay comes from the PRNG word also shown on screen as the debug value.

## Interface
- `DEBOUNCE_CYCLES`, 500_000: cycles the synchronized button level must stay stable before it is accepted (10 ms at 50 MHz).
- `DELAY_MIN`, 50_000_000: fixed part of the wait delay, in cycles.
- `DELAY_SHIFT`, 10: left shift applied to `i_rnd` to form the random part of the delay.
- `TIMEOUT`, 100_000_000: green-phase cycles before the attempt is declared late; must be < 2^28 − 1.
- `i_clk`  in  1  system clock, 50 MHz; one result LSB = 20 ns.
- `i_rst_n`  in  1  reset, synchronous, active-low.
- `i_button`  in  1  raw G16 level, asynchronous, active-high.
- `i_rnd`  in  16  PRNG word.
- `o_reaction_state`  out  3  game state code.
- `o_last_result`  out  28  last reaction time in cycles; all-ones = untracked.
- `o_best_result`  out  28  minimum valid reaction time; all-ones = none yet.
- `o_green`  out  1  high while in GREEN (LED drive).

## Operation
- Button path: 2-FF synchronizer → debouncer → rising-edge detect → one-cycle `press` pulse. Only rising edges count; holding the button generates no further pulses.
- State codes: IDLE 3'b000, WAIT 3'b001, GREEN 3'b010, LATE 3'b011, EARLY 3'b110, DONE 3'b100.
- IDLE: `press` → WAIT. In the same cycle, load the delay counter with `DELAY_MIN + (i_rnd << DELAY_SHIFT)`, computed 32 bits wide.
- WAIT: the delay counter decrements by 1 per cycle.
  - `press` before it reaches 0 → EARLY; `o_last_result` ← all-ones; best is unchanged.
  - Counter reaches 0 → GREEN, and the reaction counter is cleared to 0.
- GREEN: the reaction counter increments by 1 per cycle.
  - `press` → DONE; `o_last_result` ← counter value in that cycle; `o_best_result` ← that value if it is strictly less than the current best.
  - Counter == `TIMEOUT − 1` without a press → LATE; `o_last_result` ← all-ones.
- LATE / EARLY / DONE: `press` → IDLE. Results are held.
- A press and the timeout in the same GREEN cycle: the press wins (DONE).
- A press and the delay expiry in the same WAIT cycle: the press wins (EARLY).
- Illegal state codes recover to IDLE on the next cycle.
- Results stay stable except in the single cycle of a transition into DONE, LATE or EARLY.

## Timing
- Reset values: state IDLE (`o_reaction_state` = 3'b000), `o_last_result` = `o_best_result` = 28'hFFFFFFF, `o_green` = 0, delay/reaction/debounce counters 0, debounced level 0.
- Reset asserted mid-game returns the block to the reset values on the next clock edge. Best is cleared as well.
- Press latency from a clean `i_button` edge: 2 sync cycles + `DEBOUNCE_CYCLES` + 1 edge-detect cycle. The state changes one cycle later.
- Reported reaction time = cycles from the first GREEN cycle (count 0) to the cycle `press` is seen. The fixed pipeline latency is included and not subtracted.
- The WAIT phase lasts exactly `DELAY_MIN + (i_rnd << DELAY_SHIFT)` cycles, using the `i_rnd` sampled on the IDLE→WAIT edge.
- All outputs are registered. `o_green` is a decode of the registered state.

## Structure
- Package `reaction`:
  - `reaction_state_e`, a 3-bit enum with the codes above.
  - `RESULT_UNTRACKED` = 28'hFFFFFFF.
  - `state_transfer` should switch to this package instead of literal codes.
- Sub-module `button_debounce` (`i_clk`, `i_rst_n`, `i_raw`, `o_level`, `o_rise`): synchronizer, stability counter and edge detect.
- Everything else (FSM, delay counter, reaction counter, result registers) lives in `reaction_timer`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `DELAY_MIN`=20, `DELAY_SHIFT`=0, `TIMEOUT`=50.
- Reset, then idle 100 cycles → state 000, both results 28'hFFFFFFF, `o_green` 0.
- Press with `i_rnd`=5, then press 10 cycles after GREEN is entered → WAIT lasts 25 cycles, then DONE. `o_last_result` = `o_best_result` = 10 + fixed press latency (7). A third press → IDLE.
- Repeat with a later press (result 30), then an earlier press (result 12) → best stays 17, then becomes 12. Last tracks each attempt.
- Press again 5 cycles into WAIT → EARLY (110), last all-ones, best unchanged.
- No press in GREEN → LATE (011) exactly 50 cycles after GREEN entry, last all-ones.
- Button bounce (1-cycle glitches, 3-cycle pulses) → no state change. Reset asserted during GREEN → reset values on the next edge.
